// File: rtl/decode_queue.sv
// decode_queue: in-order queue between the decoder and dispatch.
// Up to ENQ_WIDTH decoded instructions enter per cycle. Valid lanes are
// compacted, so invalid lanes leave no holes. Up to DEQ_WIDTH head entries
// are presented per cycle, with the oldest entry in lane 0.
// Optional feature macro: DECODE_QUEUE_PERF_EN adds the perf_full_cycles
// counter port. It counts the cycles in which the decoder was paused.
module decode_queue #(
    parameter int ENQ_WIDTH  = 2,
    parameter int DEQ_WIDTH  = 2,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32   // width of one id_dispatch_t payload
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [ENQ_WIDTH-1:0]                  enq_valid,
    input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]  enq_data,
    output logic                                  pause_decoder,
    output logic [DEQ_WIDTH-1:0]                  deq_valid,
    output logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0]  deq_data,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]        deq_count,
    output logic [$clog2(DEPTH+1)-1:0]            occupancy
`ifdef DECODE_QUEUE_PERF_EN
    ,
    output logic [31:0]                           perf_full_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW1   = CNT_W + 1;

    // Dispatch reads DEQ_WIDTH arbitrary consecutive slots every cycle.
    // For that reason the storage is a register array with combinational
    // read ports rather than a single-port RAM.
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] occ_reg,  occ_next;

    logic [CW1-1:0]   room;
    logic             enq_accept;
    logic [CNT_W-1:0] enq_cnt;
    logic [CNT_W-1:0] deq_req;
    logic [CNT_W-1:0] deq_eff;

    // lane_off[i] is the number of valid lanes below lane i.
    // It gives lane i's slot offset from tail after compaction.
    logic [CNT_W-1:0] lane_off [ENQ_WIDTH+1];
    logic [PTR_W-1:0] wr_slot  [ENQ_WIDTH];

    assign lane_off[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq_lane
            assign lane_off[gi+1] = lane_off[gi] + CNT_W'(enq_valid[gi]);
            assign wr_slot[gi]    = tail_reg + PTR_W'(lane_off[gi]);
        end
    endgenerate

    generate
        for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq_lane
            logic [PTR_W-1:0] rd_slot;
            assign rd_slot       = head_reg + PTR_W'(gi);
            assign deq_data[gi]  = mem_reg[rd_slot];
            assign deq_valid[gi] = occ_reg > CNT_W'(gi);
        end
    endgenerate

    // Pause decision uses only registered occupancy. This keeps the decoder
    // stall off the dispatch timing path. The cost is that the decoder can
    // stall one cycle longer than strictly necessary.
    assign room          = CW1'(DEPTH) - {1'b0, occ_reg};
    assign pause_decoder = room < CW1'(ENQ_WIDTH);
    assign enq_accept    = ~pause_decoder;
    assign enq_cnt       = enq_accept ? lane_off[ENQ_WIDTH] : '0;

    // Dispatch may ask for more entries than are queued. Clamp so that
    // occupancy cannot underflow.
    assign deq_req   = CNT_W'(deq_count);
    assign deq_eff   = (deq_req < occ_reg) ? deq_req : occ_reg;

    assign head_next = head_reg + PTR_W'(deq_eff);
    assign tail_next = tail_reg + PTR_W'(enq_cnt);
    assign occ_next  = occ_reg + enq_cnt - deq_eff;

    assign occupancy = occ_reg;

    // Write accepted lanes into their compacted slots. Contents are not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_accept && enq_valid[i]) begin
                mem_reg[wr_slot[i]] <= enq_data[i];
            end
        end
    end

    // Pointer and occupancy update. Reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            occ_reg  <= occ_next;
        end
    end

`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0] perf_full_reg;

    // Saturating count of stalled cycles. Only reset clears it; flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_reg <= '0;
        end else if (pause_decoder && (perf_full_reg != 32'hFFFF_FFFF)) begin
            perf_full_reg <= perf_full_reg + 32'd1;
        end
    end

    assign perf_full_cycles = perf_full_reg;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed bench for decode_queue at its default parameters
// (2 enqueue lanes, 2 dequeue lanes, 8 entries).
// A behavioural queue model tracks the expected contents.
// Build with DECODE_QUEUE_PERF_EN defined to cover the stall counter.
module tb_decode_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       enq_valid;
    logic [1:0][31:0] enq_data;
    logic             pause_decoder;
    logic [1:0]       deq_valid;
    logic [1:0][31:0] deq_data;
    logic [1:0]       deq_count;
    logic [3:0]       occupancy;
`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0]      perf_full_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    logic [31:0] model_q [$];

    always #5 clk = ~clk;

    decode_queue #(
        .ENQ_WIDTH (2),
        .DEQ_WIDTH (2),
        .DEPTH     (8),
        .DATA_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .enq_valid    (enq_valid),
        .enq_data     (enq_data),
        .pause_decoder(pause_decoder),
        .deq_valid    (deq_valid),
        .deq_data     (deq_data),
        .deq_count    (deq_count),
        .occupancy    (occupancy)
`ifdef DECODE_QUEUE_PERF_EN
        ,
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Update the model from the inputs now applied, then advance one clock.
    // Outputs are sampled 1 time unit after the edge.
    task automatic step();
        int sz;
        int dn;
        bit paused;
        sz = model_q.size();
        if (rst || flush) begin
            model_q.delete();
        end else begin
            paused = (8 - sz) < 2;
            dn = (int'(deq_count) < sz) ? int'(deq_count) : sz;
            for (int i = 0; i < dn; i++) void'(model_q.pop_front());
            if (!paused) begin
                for (int i = 0; i < 2; i++) begin
                    if (enq_valid[i]) model_q.push_back(enq_data[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d: rst=%0b flush=%0b enq_valid=%b deq_count=%0d -> occupancy=%0d pause=%0b",
                 cycle, rst, flush, enq_valid, deq_count, occupancy, pause_decoder);
    endtask

    task automatic idle();
        rst       = 1'b0;
        flush     = 1'b0;
        enq_valid = 2'b00;
        deq_count = 2'd0;
    endtask

    task automatic enq2(input logic [31:0] d0, input logic [31:0] d1);
        enq_valid   = 2'b11;
        enq_data[0] = d0;
        enq_data[1] = d1;
    endtask

    task automatic check_model(input string tag);
        bit exp_v;
        check({tag, ".occ"}, 64'(occupancy), 64'(model_q.size()));
        check({tag, ".pause"}, 64'(pause_decoder), 64'((8 - model_q.size()) < 2));
        for (int i = 0; i < 2; i++) begin
            exp_v = model_q.size() > i;
            check($sformatf("%s.valid%0d", tag, i), 64'(deq_valid[i]), 64'(exp_v));
            if (exp_v) check($sformatf("%s.data%0d", tag, i), 64'(deq_data[i]), 64'(model_q[i]));
        end
    endtask

    initial begin
        int pop_idx;
        int push_idx;
        int dn;

        enq_data = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset.occ",   64'(occupancy),     64'd0);
        check("reset.valid", 64'(deq_valid),     64'd0);
        check("reset.pause", 64'(pause_decoder), 64'd0);
`ifdef DECODE_QUEUE_PERF_EN
        check("reset.perf",  64'(perf_full_cycles), 64'd0);
`endif

        // Two-lane enqueue becomes visible after one cycle.
        enq2(32'hA, 32'hB);
        step();
        idle();
        check("ab.occ",   64'(occupancy),   64'd2);
        check("ab.valid", 64'(deq_valid),   64'd3);
        check("ab.data0", 64'(deq_data[0]), 64'hA);
        check("ab.data1", 64'(deq_data[1]), 64'hB);

        deq_count = 2'd2;
        step();
        idle();
        check("drain.occ", 64'(occupancy), 64'd0);

        // Only lane 1 is valid, so compaction places it in slot 0 of the output.
        enq_valid   = 2'b10;
        enq_data[0] = 32'hDEAD;
        enq_data[1] = 32'h55;
        step();
        idle();
        check("lane1.occ",   64'(occupancy),   64'd1);
        check("lane1.valid", 64'(deq_valid),   64'd1);
        check("lane1.data0", 64'(deq_data[0]), 64'h55);

        // Fill to 7 entries. With one free slot, a full group cannot fit.
        enq2(32'h11, 32'h12); step();
        enq2(32'h13, 32'h14); step();
        check("fill5.pause", 64'(pause_decoder), 64'd0);
        enq2(32'h15, 32'h16); step();
        idle();
        check("fill7.occ",   64'(occupancy),     64'd7);
        check("fill7.pause", 64'(pause_decoder), 64'd1);

        enq2(32'h77, 32'h78); step();
        idle();
        check("paused.occ",   64'(occupancy),   64'd7);
        check("paused.data0", 64'(deq_data[0]), 64'h55);

        // Dequeue while paused. The enqueue is still ignored because the
        // pause decision uses last cycle's occupancy.
        enq2(32'h79, 32'h7A);
        deq_count = 2'd2;
        step();
        idle();
        check("unpause.occ",   64'(occupancy),     64'd5);
        check("unpause.pause", 64'(pause_decoder), 64'd0);
        check("unpause.data0", 64'(deq_data[0]),   64'h12);
        check("unpause.data1", 64'(deq_data[1]),   64'h13);
        check_model("unpause");

        // Drain. The last request asks for 2 entries with only 1 present.
        deq_count = 2'd2; step(); step(); step();
        idle();
        check("overdeq.occ", 64'(occupancy), 64'd0);
        check_model("overdeq");

        // Head is now at slot 1. Cycle 6 entries through to move it to slot 7.
        for (int k = 0; k < 3; k++) begin
            enq2(32'h40 + 32'(2*k), 32'h41 + 32'(2*k));
            step();
        end
        idle();
        deq_count = 2'd2;
        for (int k = 0; k < 3; k++) step();
        idle();
        check_model("head7");

        // Stream 20 entries across the wrap point and check strict ordering.
        pop_idx  = 0;
        push_idx = 0;
        for (int k = 0; k < 14; k++) begin
            idle();
            if (push_idx < 20) begin
                enq2(32'h100 + 32'(push_idx), 32'h101 + 32'(push_idx));
                push_idx += 2;
            end
            deq_count = (k == 0) ? 2'd0 : 2'd2;
            dn = (int'(deq_count) < model_q.size()) ? int'(deq_count) : model_q.size();
            pop_idx += dn;
            step();
            if (deq_valid[0]) check($sformatf("wrap%0d.head", k), 64'(deq_data[0]), 64'h100 + 64'(pop_idx));
            check_model($sformatf("wrap%0d", k));
        end
        idle();
        check("wrap.popped", 64'(pop_idx), 64'd20);
        check("wrap.occ",    64'(occupancy), 64'd0);

        // Flush overrides a simultaneous enqueue and dequeue.
        enq2(32'h201, 32'h202); step();
        enq2(32'h203, 32'h204); step();
        idle();
        check("preflush.occ", 64'(occupancy), 64'd4);
        flush     = 1'b1;
        deq_count = 2'd2;
        enq2(32'h205, 32'h206);
        step();
        idle();
        check("flush.occ",   64'(occupancy),     64'd0);
        check("flush.valid", 64'(deq_valid),     64'd0);
        check("flush.pause", 64'(pause_decoder), 64'd0);
        enq2(32'h301, 32'h302); step();
        idle();
        check("postflush.data0", 64'(deq_data[0]), 64'h301);
        check("postflush.data1", 64'(deq_data[1]), 64'h302);

        // Reset takes priority over flush and enqueue.
        rst   = 1'b1;
        flush = 1'b1;
        enq2(32'h401, 32'h402);
        step();
        idle();
        check("rstprio.occ",   64'(occupancy), 64'd0);
        check("rstprio.valid", 64'(deq_valid), 64'd0);

        // Completely full queue. At 6 entries the decoder is not yet paused.
        enq2(32'h501, 32'h502); step();
        enq2(32'h503, 32'h504); step();
        enq2(32'h505, 32'h506); step();
        check("occ6.pause", 64'(pause_decoder), 64'd0);
        enq2(32'h507, 32'h508); step();
        idle();
        check("full.occ",   64'(occupancy),     64'd8);
        check("full.pause", 64'(pause_decoder), 64'd1);
        check_model("full");
`ifdef DECODE_QUEUE_PERF_EN
        check("perf.start", 64'(perf_full_cycles), 64'd0);
`endif
        for (int k = 0; k < 9; k++) step();
`ifdef DECODE_QUEUE_PERF_EN
        check("perf.nine", 64'(perf_full_cycles), 64'd9);
`endif
        // The flush cycle is the tenth stalled cycle.
        flush = 1'b1;
        step();
        idle();
        check("fullflush.occ", 64'(occupancy), 64'd0);
`ifdef DECODE_QUEUE_PERF_EN
        check("perf.flush", 64'(perf_full_cycles), 64'd10);
`endif
        step(); step(); step();
`ifdef DECODE_QUEUE_PERF_EN
        check("perf.hold", 64'(perf_full_cycles), 64'd10);
        rst = 1'b1;
        step();
        idle();
        check("perf.rst", 64'(perf_full_cycles), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
